// File: rtl/hedios_pkg.sv
// Shared constants for the Hedios tx path: packet widths, endpoint command codes
// and the tx arbiter state encoding.
package hedios_pkg;

  localparam int CMD_W  = 8;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 3;

  localparam logic [CMD_W-1:0] HDC_REPLY       = 8'h03;
  localparam logic [CMD_W-1:0] HDC_LOG         = 8'h10;
  localparam logic [CMD_W-1:0] HDC_DONE        = 8'h11;
  localparam logic [CMD_W-1:0] HDC_ACTION_DONE = 8'h20;
  localparam logic [CMD_W-1:0] HDC_SLOT_UPDATE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/hedios_rr_picker.sv
// Combinational rotate-priority picker: first set request bit strictly after the
// rr pointer, wrapping around.
module hedios_rr_picker
  import hedios_pkg::*;
#(
  parameter int REQ_COUNT = 4
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [IDX_W-1:0]     rr,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_valid
);

  // Scan offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int off = REQ_COUNT; off >= 1; off--) begin
      int idx;
      idx = (int'(rr) + off) % REQ_COUNT;
      if (req[idx]) begin
        winner    = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hedios_tx_arbiter.sv
// Round-robin arbiter sharing the Hedios tx packet FIFO push port between packet
// sources, with an optional per-source lock for uninterrupted multi-packet bursts.
module hedios_tx_arbiter
  import hedios_pkg::*;
#(
  parameter int REQ_COUNT    = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REQ_COUNT-1:0]               req_valid,
  input  logic [REQ_COUNT-1:0][CMD_W-1:0]    req_command,
  input  logic [REQ_COUNT-1:0][DATA_W-1:0]   req_data,
  input  logic [REQ_COUNT-1:0]               req_last,
  output logic [REQ_COUNT-1:0]               req_ready,
  input  logic                               tx_full,
  output logic [CMD_W-1:0]                   tx_command,
  output logic [DATA_W-1:0]                  tx_data,
  output logic                               tx_push_packet,
  output logic                               lock_active,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic                               lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic                    lock_q, lock_d;
  logic [CMD_W-1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    push_q, push_d;
  logic [REQ_COUNT-1:0]    ready_q, ready_d;
  logic                    tout_q, tout_d;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [IDX_W-1:0]        acc_idx;
  logic                    sel_valid;
  logic                    sel_last;
  logic [CMD_W-1:0]        sel_cmd;
  logic [DATA_W-1:0]       sel_data;

  hedios_rr_picker #(.REQ_COUNT(REQ_COUNT)) u_picker (
    .req       (req_valid),
    .rr        (rr_q),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // While locked only the lock holder is considered; otherwise the rotation winner.
  assign acc_idx = (state_q == ST_LOCKED) ? grant_q : pick_idx;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_cmd   = '0;
    sel_data  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (acc_idx == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_cmd   = req_command[i];
        sel_data  = req_data[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    push_d  = 1'b0;
    ready_d = '0;
    tout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_full) begin
          cmd_d   = sel_cmd;
          data_d  = sel_data;
          push_d  = 1'b1;
          ready_d = REQ_COUNT'(1) << acc_idx;
          grant_d = acc_idx;
          rr_d    = acc_idx;
          last_d  = sel_last;
          lock_d  = !sel_last;
          state_d = ST_GAP;
        end else begin
          cmd_d  = '0;
          data_d = '0;
        end
      end
      ST_GAP: begin
        state_d = last_q ? ST_IDLE : ST_LOCKED;
      end
      ST_LOCKED: begin
        if (sel_valid && !tx_full) begin
          cmd_d   = sel_cmd;
          data_d  = sel_data;
          push_d  = 1'b1;
          ready_d = REQ_COUNT'(1) << acc_idx;
          grant_d = acc_idx;
          rr_d    = acc_idx;
          last_d  = sel_last;
          lock_d  = !sel_last;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (!sel_valid) begin
          // A stalled-by-full holder is still active, so only a missing valid ages the lock.
          if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            tout_d  = 1'b1;
            lock_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lock_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= IDX_W'(REQ_COUNT - 1);
      cnt_q   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
      push_q  <= 1'b0;
      ready_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      push_q  <= push_d;
      ready_q <= ready_d;
      tout_q  <= tout_d;
    end
  end

  assign req_ready      = ready_q;
  assign tx_command     = cmd_q;
  assign tx_data        = data_q;
  assign tx_push_packet = push_q;
  assign lock_active    = lock_q;
  assign grant_idx      = grant_q;
  assign lock_timeout   = tout_q;

endmodule

// File: tb/tb_hedios_tx_arbiter.sv
// Directed self-checking bench for hedios_tx_arbiter: single packets, rotation,
// locked bursts, tx_full stalls, lock timeout and reset during a burst.
module tb_hedios_tx_arbiter;
  import hedios_pkg::*;

  localparam int N  = 4;
  localparam int LT = 8;

  logic                       clk;
  logic                       rst;
  logic [N-1:0]               req_valid;
  logic [N-1:0][CMD_W-1:0]    req_command;
  logic [N-1:0][DATA_W-1:0]   req_data;
  logic [N-1:0]               req_last;
  logic [N-1:0]               req_ready;
  logic                       tx_full;
  logic [CMD_W-1:0]           tx_command;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_push_packet;
  logic                       lock_active;
  logic [IDX_W-1:0]           grant_idx;
  logic                       lock_timeout;

  int total;
  int bad;

  hedios_tx_arbiter #(.REQ_COUNT(N), .LOCK_TIMEOUT(LT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_command    (req_command),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .tx_full        (tx_full),
    .tx_command     (tx_command),
    .tx_data        (tx_data),
    .tx_push_packet (tx_push_packet),
    .lock_active    (lock_active),
    .grant_idx      (grant_idx),
    .lock_timeout   (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [CMD_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic l);
    req_valid[idx]   = v;
    req_command[idx] = c;
    req_data[idx]    = d;
    req_last[idx]    = l;
  endtask

  task automatic applyReset();
    rst         = 1'b1;
    req_valid   = '0;
    req_command = '0;
    req_data    = '0;
    req_last    = '0;
    tx_full     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " push"}, 64'(tx_push_packet), 64'd0);
    checkOutput({tag, " ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic checkPush(input string tag, input int idx, input logic [CMD_W-1:0] c);
    checkOutput({tag, " push"}, 64'(tx_push_packet), 64'd1);
    checkOutput({tag, " ready"}, 64'(req_ready), 64'(4'b0001 << idx));
    checkOutput({tag, " grant"}, 64'(grant_idx), 64'(idx));
    checkOutput({tag, " cmd"}, 64'(tx_command), 64'(c));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset values
    applyReset();
    checkIdleOutputs("rst");
    checkOutput("rst cmd", 64'(tx_command), 64'd0);
    checkOutput("rst data", 64'(tx_data), 64'd0);
    checkOutput("rst lock", 64'(lock_active), 64'd0);
    checkOutput("rst grant", 64'(grant_idx), 64'd0);
    checkOutput("rst tout", 64'(lock_timeout), 64'd0);

    // Single packet from req0, then a follow-up held valid
    applyStimulus(0, 1'b1, HDC_REPLY, 32'h0, 1'b1);
    tick();
    checkPush("single", 0, HDC_REPLY);
    checkOutput("single data", 64'(tx_data), 64'd0);
    checkOutput("single lock", 64'(lock_active), 64'd0);
    applyStimulus(0, 1'b1, 8'h04, 32'h1234_5678, 1'b1);
    tick();
    checkIdleOutputs("single gap");
    tick();
    checkPush("single next", 0, 8'h04);
    checkOutput("single next data", 64'(tx_data), 64'h1234_5678);
    applyStimulus(0, 1'b0, 8'h00, 32'h0, 1'b1);
    tick();
    tick();
    checkIdleOutputs("single drained");

    // All four requesters valid and held: strict rotation 0,1,2,3,0
    applyReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 8'(8'h10 + i), 32'(32'hA000_0000 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkPush($sformatf("rot%0d", k), k % N, 8'(8'h10 + (k % N)));
      checkOutput($sformatf("rot%0d data", k), 64'(tx_data), 64'(32'hA000_0000 + (k % N)));
      tick();
      checkIdleOutputs($sformatf("rot%0d gap", k));
    end

    // Locked burst from req1 while req2 waits
    applyReset();
    applyStimulus(1, 1'b1, HDC_SLOT_UPDATE, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, HDC_DONE, 32'h0, 1'b1);
    tick();
    checkPush("burst0", 1, 8'h80);
    checkOutput("burst0 lock", 64'(lock_active), 64'd1);
    applyStimulus(1, 1'b1, 8'h81, 32'h0, 1'b0);
    tick();
    checkIdleOutputs("burst0 gap");
    checkOutput("burst0 gap lock", 64'(lock_active), 64'd1);
    tick();
    checkPush("burst1", 1, 8'h81);
    checkOutput("burst1 lock", 64'(lock_active), 64'd1);
    applyStimulus(1, 1'b1, 8'h82, 32'h0, 1'b1);
    tick();
    checkOutput("burst1 gap lock", 64'(lock_active), 64'd1);
    tick();
    checkPush("burst2", 1, 8'h82);
    applyStimulus(1, 1'b0, 8'h00, 32'h0, 1'b1);
    tick();
    tick();
    checkPush("burst after", 2, HDC_DONE);
    checkOutput("burst after lock", 64'(lock_active), 64'd0);
    applyStimulus(2, 1'b0, 8'h00, 32'h0, 1'b1);

    // tx_full stall
    applyReset();
    tx_full = 1'b1;
    applyStimulus(0, 1'b1, 8'h05, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkIdleOutputs($sformatf("full%0d", k));
    end
    tx_full = 1'b0;
    tick();
    checkPush("full release", 0, 8'h05);
    applyStimulus(0, 1'b0, 8'h00, 32'h0, 1'b1);

    // Lock timeout after req3 abandons its lock
    applyReset();
    applyStimulus(3, 1'b1, HDC_ACTION_DONE, 32'h0, 1'b0);
    tick();
    checkPush("tmo grant", 3, HDC_ACTION_DONE);
    applyStimulus(3, 1'b0, 8'h00, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 8'h01, 32'h0, 1'b1);
    tick();
    for (int k = 1; k < LT; k++) begin
      tick();
      checkOutput($sformatf("tmo wait%0d", k), 64'(lock_timeout), 64'd0);
      checkOutput($sformatf("tmo wait%0d push", k), 64'(tx_push_packet), 64'd0);
    end
    checkOutput("tmo held lock", 64'(lock_active), 64'd1);
    tick();
    checkOutput("tmo pulse", 64'(lock_timeout), 64'd1);
    checkOutput("tmo lock drop", 64'(lock_active), 64'd0);
    checkOutput("tmo pulse push", 64'(tx_push_packet), 64'd0);
    tick();
    checkPush("tmo next", 0, 8'h01);
    checkOutput("tmo pulse clear", 64'(lock_timeout), 64'd0);
    applyStimulus(0, 1'b0, 8'h00, 32'h0, 1'b1);

    // Reset asserted while a locked packet is being pushed
    applyReset();
    applyStimulus(1, 1'b1, HDC_LOG, 32'h0, 1'b0);
    tick();
    checkPush("mid grant", 1, HDC_LOG);
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid rst");
    checkOutput("mid rst lock", 64'(lock_active), 64'd0);
    checkOutput("mid rst grant", 64'(grant_idx), 64'd0);
    checkOutput("mid rst cmd", 64'(tx_command), 64'd0);
    req_valid = '0;
    applyStimulus(2, 1'b1, 8'h22, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 8'h20, 32'h0, 1'b1);
    tick();
    checkIdleOutputs("mid held");
    rst = 1'b0;
    tick();
    checkPush("mid after", 0, 8'h20);
    tick();
    tick();
    checkPush("mid second", 2, 8'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
